ram_stream_uart: RTL

Streams a byte range of the packet buffer BRAM out over an 8N1 UART. It replaces the fixed-range raw dump path with a parametrised engine that adds:

- ring-buffer wrap-around ranges
- an abort input
- busy/done status
- an optional ASCII-hex line-formatted mode

It sits between the BRAM read port and the board UART TX pin and is triggered by debounced buttons or by the Ethernet capture logic.

---
 rtl/ram_stream_uart.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_stream_uart.sv
// Streams a (possibly wrapping) byte range of the packet buffer RAM out of an 8N1 UART.
// Define RAM_STREAM_HEX_EN to build in the ASCII-hex line-formatted output mode.

`ifndef PACKET_BUFFER_SIZE
`define PACKET_BUFFER_SIZE 2048
`endif

module ram_stream_uart #(
    parameter int RAM_SIZE     = `PACKET_BUFFER_SIZE,
    parameter int CLKS_PER_BIT = 434,
    parameter int LINE_BYTES   = 16,
    localparam int AW          = $clog2(RAM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          hex_mode,
    input  logic [AW-1:0] read_start,
    input  logic [AW-1:0] read_end,
    input  logic          ram_read_ready,
    input  logic [7:0]    ram_read_out,
    output logic          ram_read_req,
    output logic [AW-1:0] ram_read_addr,
    output logic          uart_txd,
    output logic          busy,
    output logic          done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_SIZE - 1);

`ifdef RAM_STREAM_HEX_EN
    localparam int LCW = (LINE_BYTES > 0) ? $clog2(LINE_BYTES + 1) : 1;
    localparam logic [LCW-1:0] LINE_MAX = LCW'(LINE_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, SEND_HI, SEND_LO, SEND_CR, SEND_LF, FINISH} state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    logic           hex_q, hex_d;
    logic [LCW-1:0] line_q, line_d;
`else
    typedef enum logic [2:0] {IDLE, REQ, SEND_HI, FINISH} state_t;

    logic unused_hex_mode;
    localparam int unused_line_bytes = LINE_BYTES;
    assign unused_hex_mode = hex_mode;
`endif

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   end_q, end_d;
    logic [7:0]      byte_q, byte_d;
    logic            abort_q, abort_d;
    logic [9:0]      frame_q, frame_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;

    logic            in_send;
    logic            char_done;
    logic            abort_seen;
    logic            data_done;
    logic            load;
    logic [7:0]      load_char;

    assign in_send    = (state_q != IDLE) && (state_q != REQ) && (state_q != FINISH);
    assign char_done  = in_send && (bit_q == 4'd9) && (baud_q == BAUD_MAX);
    assign abort_seen = abort_q | abort;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        byte_d    = byte_q;
        abort_d   = abort_q;
        frame_d   = frame_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_done = 1'b0;
        load      = 1'b0;
        load_char = 8'h00;
`ifdef RAM_STREAM_HEX_EN
        hex_d     = hex_q;
        line_d    = line_q;
`endif

        if (busy && abort) begin
            abort_d = 1'b1;
        end

        // Bit timer: the frame shifts right with idle-high fill, so bit 0 is always the line level.
        if (in_send) begin
            if (baud_q == BAUD_MAX) begin
                baud_d  = '0;
                bit_d   = bit_q + 4'd1;
                frame_d = {1'b1, frame_q[9:1]};
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (read_start == read_end) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = read_start;
                        end_d   = read_end;
                        abort_d = 1'b0;
`ifdef RAM_STREAM_HEX_EN
                        hex_d   = hex_mode;
                        line_d  = '0;
`endif
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (ram_read_ready) begin
                    byte_d    = ram_read_out;
                    addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    load      = 1'b1;
                    load_char = ram_read_out;
`ifdef RAM_STREAM_HEX_EN
                    if (hex_q) begin
                        load_char = hex_ascii(ram_read_out[7:4]);
                    end
`endif
                    state_d   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (char_done) begin
`ifdef RAM_STREAM_HEX_EN
                    if (hex_q) begin
                        load      = 1'b1;
                        load_char = hex_ascii(byte_q[3:0]);
                        state_d   = SEND_LO;
                    end else begin
                        data_done = 1'b1;
                    end
`else
                    data_done = 1'b1;
`endif
                end
            end
`ifdef RAM_STREAM_HEX_EN
            SEND_LO: begin
                if (char_done) begin
                    data_done = 1'b1;
                end
            end
            SEND_CR: begin
                if (char_done) begin
                    load      = 1'b1;
                    load_char = 8'h0A;
                    state_d   = SEND_LF;
                end
            end
            SEND_LF: begin
                if (char_done) begin
                    state_d = (abort_seen || addr_q == end_q) ? FINISH : REQ;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (data_done) begin
`ifdef RAM_STREAM_HEX_EN
            // An abort drops a line break that has not started yet.
            if (hex_q && LINE_BYTES != 0 && (line_q + 1'b1) == LINE_MAX && !abort_seen) begin
                line_d    = '0;
                load      = 1'b1;
                load_char = 8'h0D;
                state_d   = SEND_CR;
            end else begin
                if (hex_q && LINE_BYTES != 0) begin
                    line_d = line_q + 1'b1;
                end
                state_d = (abort_seen || addr_q == end_q) ? FINISH : REQ;
            end
`else
            state_d = (abort_seen || addr_q == end_q) ? FINISH : REQ;
`endif
        end

        if (load) begin
            frame_d = {1'b1, load_char, 1'b0};
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            byte_q  <= '0;
            abort_q <= 1'b0;
            frame_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
`ifdef RAM_STREAM_HEX_EN
            hex_q   <= 1'b0;
            line_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            byte_q  <= byte_d;
            abort_q <= abort_d;
            frame_q <= frame_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
`ifdef RAM_STREAM_HEX_EN
            hex_q   <= hex_d;
            line_q  <= line_d;
`endif
        end
    end

    assign uart_txd      = frame_q[0];
    assign ram_read_req  = (state_q == REQ);
    assign ram_read_addr = addr_q;
    assign busy          = (state_q != IDLE) && (state_q != FINISH);
    assign done          = (state_q == FINISH);

endmodule
